adder_error_monitor16: RTL
==========================

Name: adder_error_monitor16

Overview:
- Sequential stage directly downstream of the 16-bit approximate adders.
- Consumes each operand pair together with the adder's (WIDTH+1)-bit result, recomputes the exact sum and measures the error distance (ED).
- Accumulates error statistics over a fixed window of 2^SAMPLE_CNT_W samples and holds the totals for readout.
- Used in characterisation benches and on-chip self-test of every adder variant.

Parameters:
- WIDTH, 16: operand width; the result and approx inputs are WIDTH+1 bits.
- SAMPLE_CNT_W, 10: log2 of the window length N; N = 1024 by default.
- ED_ACC_W, WIDTH+1+SAMPLE_CNT_W: width of the ED sum accumulator; cannot overflow over one window.

Ports:
- clk_i  input  1  clock, all state on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle request to begin a new window.
- valid_i  input  1  sample present on add1_i/add2_i/approx_i.
- ready_o  output  1  monitor accepts a sample this cycle.
- add1_i  input  WIDTH  operand A fed to the adder under test.
- add2_i  input  WIDTH  operand B fed to the adder under test.
- approx_i  input  WIDTH+1  result produced by the adder under test.
- busy_o  output  1  window in progress (RUN or DRAIN).
- done_o  output  1  high while the statistics are valid (DONE).
- err_count_o  output  SAMPLE_CNT_W+1  number of samples with approx != exact.
- ed_sum_o  output  ED_ACC_W  sum of |approx - exact| over the window.
- max_ed_o  output  WIDTH+1  largest single ED (see Optional Feature).

Behaviour:
- Reset: the FSM goes to IDLE and every output is 0 (ready_o, busy_o, done_o, err_count_o, ed_sum_o, max_ed_o). The internal sample counter and pipeline valid bits are cleared. A reset in any state, including mid-window, discards partial results.
- FSM states:
  - IDLE: ready_o = 0. start_i -> RUN; accumulators and the sample counter are cleared on that edge.
  - RUN: ready_o = 1 while accepted < N. A sample is accepted on a cycle where valid_i && ready_o. When the Nth sample is accepted, ready_o drops the next cycle and the FSM goes to DRAIN. start_i is ignored.
  - DRAIN: waits until both pipeline stages are empty, then goes to DONE. The number of wait cycles is fixed by the pipeline depth.
  - DONE: done_o = 1 and outputs are held stable. start_i -> RUN with accumulators cleared, and done_o falls the next cycle.
- Pipeline, 2 stages:
  - S1 registers add1_i, add2_i and approx_i on accept.
  - S2 computes exact = add1 + add2 zero-extended to WIDTH+1 bits, and ED = |approx - exact| using a WIDTH+2-bit signed difference. It then updates the accumulators.
  - Latency from accept to the accumulator update is 2 cycles.
  - Once the last sample is accepted, done_o rises no earlier than 3 cycles later.
- Accumulator update in S2:
  - if ED != 0, err_count += 1;
  - ed_sum += ED;
  - max_ed = max(max_ed, ED).
- Width rules: err_count_o saturation is never reached, since its maximum is N and fits SAMPLE_CNT_W+1 bits. ed_sum_o maximum is N*(2^(WIDTH+1)-1) and fits ED_ACC_W.
- Boundaries:
  - valid_i gaps in RUN stall only the acceptance count; no timeout.
  - Operand wrap: exact sum of 0xFFFF+0xFFFF = 0x1FFFE is carried in bit WIDTH and is never truncated.
  - approx_i greater than exact and less than exact both give a positive ED.
  - start_i asserted in the same cycle as rst_i: reset wins.

Optional Feature:
- Macro ADDER_ERR_MON_MAX_ED_EN.
- Defined: the max_ed register and comparator are present, and max_ed_o reports the window maximum.
- Undefined: no register or comparator is built, and max_ed_o is tied to 0 permanently.

Decomposition:
- Shared package adder_mon_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - default constants WIDTH = 16 and SAMPLE_CNT_W = 10;
  - a localparam function for ED_ACC_W.
- One natural sub-module, error_distance_calc: a combinational block that takes (a, b, approx) and returns (exact, ed, mismatch), instantiated in S2.

Test Plan:
- Exact adder model, N = 1024 random samples with valid_i held high -> done_o high 3 cycles after the last accept; err_count_o = 0, ed_sum_o = 0, max_ed_o = 0.
- Model returning a+b+1 for all samples -> err_count_o = 1024, ed_sum_o = 1024, max_ed_o = 1.
- Single-window sample with a = 0xFFFF, b = 0xFFFF, approx = 0x00000 (all others exact) -> err_count_o = 1, ed_sum_o = 0x1FFFE, max_ed_o = 0x1FFFE (0 if the macro is undefined).
- valid_i toggled pseudo-randomly at 50% duty -> totals identical to the back-to-back run; ready_o deasserts exactly after the 1024th accept.
- rst_i pulsed after 500 accepts, then start_i -> all outputs 0 after reset; the new window counts exactly 1024 fresh samples.
- start_i pulsed during RUN and again in DONE -> the first pulse is ignored; the second clears the accumulators and done_o falls the next cycle.

Source files
------------

// File: rtl/adder_error_monitor16_pkg.sv
// Shared types and defaults for the approximate-adder error monitor.
// Combinational only; no flow control.
package adder_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mon_state_t;

  localparam int DEF_WIDTH        = 16;
  localparam int DEF_SAMPLE_CNT_W = 10;

  // Sized so a full window of worst-case errors cannot overflow the sum.
  function automatic int ed_acc_width(input int width, input int sample_cnt_w);
    return width + 1 + sample_cnt_w;
  endfunction

endpackage

// File: rtl/adder_error_monitor16_error_distance_calc.sv
// Exact sum and error distance |approx - exact| for one operand pair; combinational.
// No flow control; consumed by the monitor's second pipeline stage.
module error_distance_calc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   exact,
  output logic [WIDTH:0]   ed,
  output logic             mismatch
);

  logic [WIDTH+1:0] diff;

  always_comb begin
    exact    = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, approx} - {1'b0, exact};
    // Top bit is the two's-complement sign; magnitude always fits WIDTH+1 bits.
    ed       = diff[WIDTH+1] ? (~diff[WIDTH:0] + 1'b1) : diff[WIDTH:0];
    mismatch = (approx != exact);
  end

endmodule

// File: rtl/adder_error_monitor16.sv
// Windowed error statistics for an approximate adder; 2-cycle accept-to-accumulate, done 3 cycles after last accept.
// ready_o high only in RUN until 2^SAMPLE_CNT_W samples are taken; max_ed_o built only with ADDER_ERR_MON_MAX_ED_EN.
module adder_error_monitor16
  import adder_mon_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int SAMPLE_CNT_W = DEF_SAMPLE_CNT_W,
  parameter int ED_ACC_W     = ed_acc_width(WIDTH, SAMPLE_CNT_W)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [WIDTH-1:0]        add1_i,
  input  logic [WIDTH-1:0]        add2_i,
  input  logic [WIDTH:0]          approx_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [SAMPLE_CNT_W:0]   err_count_o,
  output logic [ED_ACC_W-1:0]     ed_sum_o,
  output logic [WIDTH:0]          max_ed_o
);

  localparam logic [SAMPLE_CNT_W-1:0] LAST_IDX = '1;

  mon_state_t              state;
  logic [SAMPLE_CNT_W-1:0] acc_cnt;
  logic                    accept;
  logic                    clear_acc;

  logic                    s1_vld;
  logic [WIDTH-1:0]        s1_a;
  logic [WIDTH-1:0]        s1_b;
  logic [WIDTH:0]          s1_approx;
  logic [WIDTH:0]          s1_ed;
  logic                    s1_mismatch;
  logic [WIDTH:0]          exact_unused;

  logic                    s2_vld;
  logic [WIDTH:0]          s2_ed;
  logic                    s2_err;

  assign accept    = valid_i && ready_o;
  assign clear_acc = start_i && (state == IDLE || state == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      acc_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state   <= RUN;
            ready_o <= 1'b1;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            acc_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == LAST_IDX) begin
              ready_o <= 1'b0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Fixed wait: the two pipeline stages empty in two cycles.
          if (!s1_vld && !s2_vld) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  error_distance_calc #(
    .WIDTH(WIDTH)
  ) u_edc (
    .a        (s1_a),
    .b        (s1_b),
    .approx   (s1_approx),
    .exact    (exact_unused),
    .ed       (s1_ed),
    .mismatch (s1_mismatch)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld      <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_approx   <= '0;
      s2_vld      <= 1'b0;
      s2_ed       <= '0;
      s2_err      <= 1'b0;
      err_count_o <= '0;
      ed_sum_o    <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a      <= add1_i;
        s1_b      <= add2_i;
        s1_approx <= approx_i;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_ed  <= s1_ed;
        s2_err <= s1_mismatch;
      end
      if (clear_acc) begin
        err_count_o <= '0;
        ed_sum_o    <= '0;
      end else if (s2_vld) begin
        err_count_o <= err_count_o + {{SAMPLE_CNT_W{1'b0}}, s2_err};
        ed_sum_o    <= ed_sum_o + ED_ACC_W'(s2_ed);
      end
    end
  end

`ifdef ADDER_ERR_MON_MAX_ED_EN
  logic [WIDTH:0] max_ed_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_ed_q <= '0;
    end else if (clear_acc) begin
      max_ed_q <= '0;
    end else if (s2_vld && (s2_ed > max_ed_q)) begin
      max_ed_q <= s2_ed;
    end
  end

  assign max_ed_o = max_ed_q;
`else
  assign max_ed_o = '0;
`endif

endmodule
